uart_baud_gen: RTL and testbench

- Parametrised baud-rate generator for the UART TX and RX paths; next generation of the fixed TX clock divider.
- Runtime-programmable divisor produces two tick streams: a one-cycle oversample strobe for the RX sampler and a one-cycle bit strobe for the TX shifter.
- Also produces a 50%-duty legacy tx_clock for existing consumers.
- Sits between the system oscillator domain and the uart_tx / uart_rx blocks; all outputs stay in the clk domain.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tick_counter.sv | 37 +++
 rtl/uart_baud_gen.sv | 148 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART baud-rate generator and its consumers.
//   UART_OVERSAMPLE_DEF : default number of oversample ticks per bit
//   UART_DIV_W          : default prescaler divisor width
//   baud_div_t          : prescaler divisor type at the default width
//   calc_def_div()      : rounded divisor for a clock / baud / oversample set
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_OVERSAMPLE_DEF = 16;
    localparam int UART_DIV_W          = 16;

    typedef logic [UART_DIV_W-1:0] baud_div_t;

    // round(sys_clk / (baud * os)) using integer arithmetic; 64-bit
    // intermediates keep large oversample products from overflowing.
    function automatic int calc_def_div(input longint sys_clk,
                                        input longint baud,
                                        input longint os);
        longint den;
        den = baud * os;
        if (den <= 0) begin
            return 0;
        end
        return int'((sys_clk + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// -----------------------------------------------------------------------------
// uart_tick_counter
// Modulo counter with run enable, synchronous clear and terminal-count flag.
// Counts 0 .. last and wraps to 0; 'last' may change at run time.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   enable : count advances when high, holds when low
//   clear  : forces the count to 0 on the next edge (wins over enable)
//   last   : terminal value (modulus - 1)
//   count  : current count
//   tc     : high in the enabled cycle in which the count wraps
// -----------------------------------------------------------------------------
module uart_tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = enable & (count == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Programmable baud-rate generator for the UART TX and RX paths.
// A prescaler divides clk by a run-time divisor D to make the oversample
// strobe; an oversample counter divides that by OVERSAMPLE to make the bit
// strobe and the 50%-duty legacy tx_clock. New divisors are held pending and
// only applied on a bit boundary (or immediately while stopped / cleared).
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   enable      : counters run when high, freeze when low
//   sync_clr    : one-cycle pulse, zeroes both counters and tx_clock
//   div_load    : one-cycle pulse, captures div_value as the pending divisor
//   div_value   : new divisor in clk cycles per oversample tick (0 acts as 1)
//   os_tick     : one-cycle strobe per prescaler period
//   bit_tick    : one-cycle strobe per OVERSAMPLE os_ticks
//   tx_clock    : square wave, period OVERSAMPLE*D cycles, 50% duty
//   div_pending : high while a loaded divisor waits to be applied
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 25000000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = UART_OVERSAMPLE_DEF,
    parameter int DIV_WIDTH    = UART_DIV_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 sync_clr,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 os_tick,
    output logic                 bit_tick,
    output logic                 tx_clock,
    output logic                 div_pending
);

    localparam int DEF_DIV = calc_def_div(SYSTEM_CLOCK, DEFAULT_BAUD, OVERSAMPLE);
    localparam int OS_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_WIDTH-1:0] DEF_DIV_V = DIV_WIDTH'(DEF_DIV);
    localparam logic [OS_W-1:0]      OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]      OS_HALF   = OS_W'(OVERSAMPLE / 2);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_baud_gen: OVERSAMPLE must be even and at least 4");
    end

    if ((longint'(DEF_DIV) >> DIV_WIDTH) != 0) begin : g_bad_default_div
        $error("uart_baud_gen: default divisor does not fit in DIV_WIDTH");
    end

    // A zero divisor behaves as one: a tick every enabled cycle.
    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] pend_val;
    logic [DIV_WIDTH-1:0] pre_last;
    logic [DIV_WIDTH-1:0] pre_cnt_unused;
    logic [OS_W-1:0]      os_cnt;
    logic                 run;
    logic                 os_adv;
    logic                 bit_adv;
    logic                 apply_win;
    logic                 apply_now;
    logic                 pre_clr;

    // sync_clr outranks enable: a clearing cycle never counts or ticks.
    assign run      = enable & ~sync_clr;
    assign pre_last = eff_div(divisor) - DIV_WIDTH'(1);

    // A divisor may change only where no bit is in flight: on a bit boundary,
    // while stopped, or while being cleared. Applying restarts the prescaler so
    // its count never sits beyond the new terminal value.
    assign apply_win = ~enable | sync_clr | bit_adv;
    assign apply_now = apply_win & (div_pending | div_load);
    assign pre_clr   = sync_clr | apply_now;

    uart_tick_counter #(
        .W (DIV_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (run),
        .clear  (pre_clr),
        .last   (pre_last),
        .count  (pre_cnt_unused),
        .tc     (os_adv)
    );

    uart_tick_counter #(
        .W (OS_W)
    ) u_os_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (os_adv),
        .clear  (sync_clr),
        .last   (OS_LAST),
        .count  (os_cnt),
        .tc     (bit_adv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_tick     <= 1'b0;
            bit_tick    <= 1'b0;
            tx_clock    <= 1'b0;
            divisor     <= DEF_DIV_V;
            div_pending <= 1'b0;
        end else begin
            os_tick  <= os_adv;
            bit_tick <= bit_adv;

            // tx_clock rises on the 0->1 oversample step and falls on the
            // OVERSAMPLE/2 -> OVERSAMPLE/2+1 step, giving an even split.
            if (sync_clr) begin
                tx_clock <= 1'b0;
            end else if (os_adv && os_cnt == '0) begin
                tx_clock <= 1'b1;
            end else if (os_adv && os_cnt == OS_HALF) begin
                tx_clock <= 1'b0;
            end

            // A load landing in an apply cycle bypasses the pending register.
            if (apply_win) begin
                if (div_load) begin
                    divisor <= div_value;
                end else if (div_pending) begin
                    divisor <= pend_val;
                end
                div_pending <= 1'b0;
            end else if (div_load) begin
                div_pending <= 1'b1;
            end
        end
    end

    // Pending value is qualified by div_pending, so it needs no reset.
    always_ff @(posedge clk) begin
        if (div_load && !apply_win) begin
            pend_val <= div_value;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
// Self-checking bench for uart_baud_gen with the default parameters.
// A behavioural model tracks enabled cycles since the last prescaler restart
// and oversample ticks modulo OVERSAMPLE; expected outputs follow from those.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int OS  = 16;
    localparam int DEF = 163;

    logic      clk      = 1'b0;
    logic      rst_n    = 1'b0;
    logic      enable   = 1'b0;
    logic      sync_clr = 1'b0;
    logic      div_load = 1'b0;
    baud_div_t div_value = '0;
    logic      os_tick;
    logic      bit_tick;
    logic      tx_clock;
    logic      div_pending;

    int total = 0;
    int bad   = 0;

    // reference model state
    int   m_div;
    int   m_pval;
    int   m_t;
    int   m_k;
    logic m_pend;
    logic m_os;
    logic m_bt;

    always #5 clk = ~clk;

    uart_baud_gen #(
        .SYSTEM_CLOCK (25000000),
        .DEFAULT_BAUD (9600),
        .OVERSAMPLE   (OS),
        .DIV_WIDTH    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sync_clr    (sync_clr),
        .div_load    (div_load),
        .div_value   (div_value),
        .os_tick     (os_tick),
        .bit_tick    (bit_tick),
        .tx_clock    (tx_clock),
        .div_pending (div_pending)
    );

    task automatic model_reset();
        m_div  = DEF;
        m_pval = 0;
        m_t    = 0;
        m_k    = 0;
        m_pend = 1'b0;
        m_os   = 1'b0;
        m_bt   = 1'b0;
    endtask

    task automatic model_edge();
        int eff;
        eff  = (m_div == 0) ? 1 : m_div;
        m_os = 1'b0;
        m_bt = 1'b0;
        if (sync_clr) begin
            m_t = 0;
            m_k = 0;
        end else if (enable) begin
            m_t++;
            if (m_t % eff == 0) begin
                m_os = 1'b1;
                m_k  = (m_k + 1) % OS;
                if (m_k == 0) m_bt = 1'b1;
            end
        end
        if (!enable || sync_clr || m_bt) begin
            if (div_load) begin
                m_div = int'(div_value);
                m_t   = 0;
            end else if (m_pend) begin
                m_div = m_pval;
                m_t   = 0;
            end
            m_pend = 1'b0;
        end else if (div_load) begin
            m_pend = 1'b1;
            m_pval = int'(div_value);
        end
    endtask

    // {os_tick, bit_tick, tx_clock, div_pending} as the model expects them
    function automatic logic [3:0] model_v();
        return {m_os, m_bt, (m_k >= 1 && m_k <= OS / 2), m_pend};
    endfunction

    task automatic tick(input logic en, input logic clr, input logic ld, input baud_div_t val);
        enable    = en;
        sync_clr  = clr;
        div_load  = ld;
        div_value = val;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick(1'b1, 1'b0, 1'b1, 16'd5);
        total++;
        if ({os_tick, bit_tick, tx_clock, div_pending} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000", {os_tick, bit_tick, tx_clock, div_pending});
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, '0);
        total++;
        if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", {os_tick, bit_tick, tx_clock, div_pending}, model_v());
        end
    endtask

    task automatic test_default_rate();
        int first_os = 0;
        int b1 = 0;
        int b2 = 0;
        int txh = 0;
        for (int c = 1; c <= 5220; c++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL default_cycle c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
            if (os_tick && first_os == 0) first_os = c;
            if (bit_tick) begin
                if (b1 == 0) b1 = c;
                else if (b2 == 0) b2 = c;
            end
            if (b1 != 0 && b2 == 0 && tx_clock) txh++;
        end
        total++;
        if (first_os != DEF) begin
            bad++;
            $display("FAIL default_first_os got=%0d exp=%0d", first_os, DEF);
        end
        total++;
        if (b1 != 2608 || b2 - b1 != 2608) begin
            bad++;
            $display("FAIL default_bit_period got=%0d,%0d exp=2608,2608", b1, b2 - b1);
        end
        total++;
        if (txh != 1304) begin
            bad++;
            $display("FAIL default_tx_high got=%0d exp=1304", txh);
        end
    endtask

    task automatic test_div4_pending();
        logic found = 1'b0;
        int   n_os = 0;
        int   n_bit = 0;
        int   last_bit = 0;
        int   txh = 0;
        tick(1'b1, 1'b0, 1'b1, 16'd4);
        total++;
        if (div_pending !== 1'b1) begin
            bad++;
            $display("FAIL div4_pending_set got=%b exp=1", div_pending);
        end
        for (int i = 0; i < 3000 && !found; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL div4_wait i=%0d got=%b exp=%b", i, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
            if (bit_tick) found = 1'b1;
        end
        total++;
        if (!found || div_pending !== 1'b0) begin
            bad++;
            $display("FAIL div4_apply got=found%0d,pend%b exp=found1,pend0", found, div_pending);
        end
        for (int c = 1; c <= 192; c++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL div4_run c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
            if (os_tick) n_os++;
            if (bit_tick) begin
                n_bit++;
                last_bit = c;
            end
            if (tx_clock) txh++;
        end
        total++;
        if (n_os != 48 || n_bit != 3 || last_bit != 192 || txh != 96) begin
            bad++;
            $display("FAIL div4_rates got=os%0d,bit%0d,last%0d,txh%0d exp=os48,bit3,last192,txh96",
                     n_os, n_bit, last_bit, txh);
        end
    endtask

    task automatic test_mid_bit_change();
        int b1 = 0;
        int b2 = 0;
        tick(1'b1, 1'b1, 1'b1, 16'd10);
        for (int c = 1; c <= 230; c++) begin
            tick(1'b1, 1'b0, (c == 51), (c == 51) ? 16'd4 : 16'd0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL midbit_cycle c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
            if (bit_tick) begin
                if (b1 == 0) b1 = c;
                else if (b2 == 0) b2 = c;
            end
        end
        total++;
        if (b1 != 160 || b2 != 224) begin
            bad++;
            $display("FAIL midbit_bits got=%0d,%0d exp=160,224", b1, b2);
        end
    endtask

    task automatic test_small_div();
        for (int v = 0; v <= 1; v++) begin
            int n_os = 0;
            int n_bit = 0;
            int b1 = 0;
            tick(1'b1, 1'b1, 1'b1, baud_div_t'(v));
            for (int c = 1; c <= 40; c++) begin
                tick(1'b1, 1'b0, 1'b0, '0);
                total++;
                if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                    bad++;
                    $display("FAIL smalldiv_cycle v=%0d c=%0d got=%b exp=%b", v, c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
                end
                if (os_tick) n_os++;
                if (bit_tick) begin
                    n_bit++;
                    if (b1 == 0) b1 = c;
                end
            end
            total++;
            if (n_os != 40 || n_bit != 2 || b1 != 16) begin
                bad++;
                $display("FAIL smalldiv_rates v=%0d got=os%0d,bit%0d,first%0d exp=os40,bit2,first16", v, n_os, n_bit, b1);
            end
        end
    endtask

    task automatic test_sync_clr();
        int d = $urandom_range(3, 12);
        int n = 7 * d + $urandom_range(0, d - 1);
        int first_os = 0;
        int first_bit = 0;
        tick(1'b1, 1'b1, 1'b1, baud_div_t'(d));
        for (int c = 1; c <= n; c++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL syncclr_pre c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
        end
        tick(1'b1, 1'b1, 1'b0, '0);
        total++;
        if ({os_tick, bit_tick, tx_clock} !== 3'b000) begin
            bad++;
            $display("FAIL syncclr_outputs got=%b exp=000", {os_tick, bit_tick, tx_clock});
        end
        for (int c = 1; c <= 16 * d + 2; c++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL syncclr_post c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
            if (os_tick && first_os == 0) first_os = c;
            if (bit_tick && first_bit == 0) first_bit = c;
        end
        total++;
        if (first_os != d || first_bit != 16 * d) begin
            bad++;
            $display("FAIL syncclr_realign d=%0d got=%0d,%0d exp=%0d,%0d", d, first_os, first_bit, d, 16 * d);
        end
    endtask

    task automatic test_pause_and_reset();
        int   d = $urandom_range(3, 9);
        int   r = $urandom_range(20, 16 * d - 1);
        int   paused_ticks = 0;
        int   n = 0;
        int   first_os = 0;
        logic found = 1'b0;
        tick(1'b1, 1'b1, 1'b1, baud_div_t'(d));
        for (int c = 1; c <= r; c++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL pause_pre c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
        end
        for (int c = 1; c <= 50; c++) begin
            tick(1'b0, 1'b0, 1'b0, '0);
            if (os_tick || bit_tick) paused_ticks++;
        end
        total++;
        if (paused_ticks != 0) begin
            bad++;
            $display("FAIL pause_ticks got=%0d exp=0", paused_ticks);
        end
        for (int c = 1; c <= 16 * d + 5 && !found; c++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL pause_resume c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
            n = c;
            if (bit_tick) found = 1'b1;
        end
        total++;
        if (!found || n != 16 * d - r) begin
            bad++;
            $display("FAIL pause_remaining d=%0d r=%0d got=%0d exp=%0d", d, r, n, 16 * d - r);
        end
        repeat (d + 1) tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b1, 16'd7);
        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({os_tick, bit_tick, tx_clock, div_pending} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0000", {os_tick, bit_tick, tx_clock, div_pending});
        end
        tick(1'b1, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        for (int c = 1; c <= 170; c++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL post_reset c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
            if (os_tick && first_os == 0) first_os = c;
        end
        total++;
        if (first_os != DEF) begin
            bad++;
            $display("FAIL reset_divisor got=%0d exp=%0d", first_os, DEF);
        end
    endtask

    task automatic test_random();
        for (int c = 1; c <= 3000; c++) begin
            tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) == 0), baud_div_t'($urandom_range(0, 6)));
            total++;
            if ({os_tick, bit_tick, tx_clock, div_pending} !== model_v()) begin
                bad++;
                $display("FAIL random c=%0d got=%b exp=%b", c, {os_tick, bit_tick, tx_clock, div_pending}, model_v());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_rate();
        test_div4_pending();
        test_mid_bit_change();
        test_small_div();
        test_sync_clr();
        test_pause_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
